// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the ID-stage load-use hazard / stall
// controller (hazard_stall_ctrl) and its load scoreboard (hz_load_scoreboard).
//   hz_state_e     : informational FSM state reported on state_o
//   hz_ctrl_t      : bundle of the four pipeline control outputs
//   CTRL_*         : the three control encodings the priority mux selects from
//   HZ_REG_ADDR_W  : default register address width (RV32: 5 bits)
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int HZ_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_FREEZE = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic stall;
        logic noop;
        logic freeze;
    } hz_ctrl_t;

    // Normal flow (also used for reset and flush).
    localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, stall: 1'b0, noop: 1'b0, freeze: 1'b0};
    // Load-use: hold PC and IF/ID, push a bubble into ID/EX.
    localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, stall: 1'b1, noop: 1'b1, freeze: 1'b0};
    // Cache miss: everything holds, no bubble (ID/EX is itself frozen).
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, stall: 1'b1, noop: 1'b0, freeze: 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundles the pipeline-facing signals of hazard_stall_ctrl.
//   Inputs to the controller : ID_rs_i, ID_rs_used_i, EX_MemRead_i, EX_rd_i,
//                              mem_stall_i, flush_i, cnt_clr_i
//   Outputs of the controller: PCWrite_o, Stall_o, NoOp_o, Freeze_o,
//                              state_o, stall_cnt_o
// modport master : the pipeline side (drives the inputs)
// modport slave  : the controller side
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int CNT_W      = 16
);
    logic [NUM_SRC*REG_ADDR_W-1:0] ID_rs_i;
    logic [NUM_SRC-1:0]            ID_rs_used_i;
    logic                          EX_MemRead_i;
    logic [REG_ADDR_W-1:0]         EX_rd_i;
    logic                          mem_stall_i;
    logic                          flush_i;
    logic                          cnt_clr_i;

    logic                          PCWrite_o;
    logic                          Stall_o;
    logic                          NoOp_o;
    logic                          Freeze_o;
    logic [1:0]                    state_o;
    logic [CNT_W-1:0]              stall_cnt_o;

    modport master (
        output ID_rs_i, ID_rs_used_i, EX_MemRead_i, EX_rd_i,
               mem_stall_i, flush_i, cnt_clr_i,
        input  PCWrite_o, Stall_o, NoOp_o, Freeze_o, state_o, stall_cnt_o
    );

    modport slave (
        input  ID_rs_i, ID_rs_used_i, EX_MemRead_i, EX_rd_i,
               mem_stall_i, flush_i, cnt_clr_i,
        output PCWrite_o, Stall_o, NoOp_o, Freeze_o, state_o, stall_cnt_o
    );

endinterface

// File: rtl/hz_load_scoreboard.sv
// -----------------------------------------------------------------------------
// hz_load_scoreboard
// Tracks loads that have left EX but whose data is not yet forwardable.
// DEPTH-entry {valid, rd} shift register, entry 0 youngest; the whole chain
// holds while 'hold' is high. 'match[k]' flags that source k equals the rd of
// any valid entry. With DEPTH=0 there is no storage and match is all zero.
//   clk, srst   : clock, synchronous active-high reset (clears valid bits)
//   hold        : freeze all entries
//   push_valid  : load leaving EX this cycle (rd already known non-zero)
//   push_rd     : its destination register
//   rs          : NUM_SRC packed source register addresses
//   match       : per-source hit against the scoreboard
// -----------------------------------------------------------------------------
module hz_load_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int DEPTH      = 0
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          hold,
    input  logic                          push_valid,
    input  logic [REG_ADDR_W-1:0]         push_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs,
    output logic [NUM_SRC-1:0]            match
);

    genvar gi, gj;

    generate
        if (DEPTH == 0) begin : g_empty
            // Single-cycle load latency: the EX comparison in the parent is
            // all that is needed.
            logic unused_inputs;
            assign unused_inputs = ^{clk, srst, hold, push_valid, push_rd, rs};
            assign match = '0;
        end else begin : g_sb
            logic [DEPTH-1:0]      valid_reg;
            logic [REG_ADDR_W-1:0] rd_reg [DEPTH];

            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        rd_reg[j] <= '0;
                    end
                end else if (!hold) begin
                    valid_reg[0] <= push_valid;
                    rd_reg[0]    <= push_rd;
                    for (int j = 1; j < DEPTH; j++) begin
                        valid_reg[j] <= valid_reg[j-1];
                        rd_reg[j]    <= rd_reg[j-1];
                    end
                end
            end

            for (gi = 0; gi < NUM_SRC; gi++) begin : g_match
                logic [DEPTH-1:0] hit;
                for (gj = 0; gj < DEPTH; gj++) begin : g_ent
                    assign hit[gj] = valid_reg[gj] &&
                                     (rd_reg[gj] == rs[gi*REG_ADDR_W +: REG_ADDR_W]);
                end
                assign match[gi] = |hit;
            end
        end
    endgenerate

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// ID-stage load-use hazard detection and stall control for the pipelined core.
// Generalised for a LOAD_LAT-cycle load-to-forward latency, NUM_SRC source
// operands, a whole-pipeline freeze on D-cache miss, and flush priority.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous reset, active high
//   bus     : hazard_stall_ctrl_if.slave
//             in : ID_rs_i, ID_rs_used_i, EX_MemRead_i, EX_rd_i,
//                  mem_stall_i, flush_i, cnt_clr_i
//             out: PCWrite_o, Stall_o, NoOp_o, Freeze_o (combinational),
//                  state_o (registered debug state), stall_cnt_o (saturating)
// Output priority: reset > cache-miss freeze > flush > load hazard > run.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);

    localparam int               SB_DEPTH = LOAD_LAT - 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_SRC-1:0] sb_match;
    logic [NUM_SRC-1:0] src_hit;
    logic               hazard;
    logic               sb_push_valid;
    hz_ctrl_t           ctrl;
    hz_state_e          state_reg;
    hz_state_e          state_next;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [CNT_W-1:0]   stall_cnt_next;

    // The load in EX moves on to MEM even when a bubble is inserted behind it,
    // so it is recorded regardless of NoOp; x0 never needs tracking.
    assign sb_push_valid = bus.EX_MemRead_i && (bus.EX_rd_i != '0);

    hz_load_scoreboard #(
        .NUM_SRC    (NUM_SRC),
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (SB_DEPTH)
    ) u_scoreboard (
        .clk        (clk_i),
        .srst       (rst_i),
        .hold       (ctrl.freeze),
        .push_valid (sb_push_valid),
        .push_rd    (bus.EX_rd_i),
        .rs         (bus.ID_rs_i),
        .match      (sb_match)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_ADDR_W-1:0] rs;
            logic                  ex_hit;
            assign rs          = bus.ID_rs_i[gi*REG_ADDR_W +: REG_ADDR_W];
            assign ex_hit      = bus.EX_MemRead_i && (rs == bus.EX_rd_i);
            assign src_hit[gi] = bus.ID_rs_used_i[gi] && (rs != '0) &&
                                 (ex_hit || sb_match[gi]);
        end
    endgenerate

    assign hazard = |src_hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // The state simply records which priority case won this cycle; leaving
    // MEM_FREEZE needs no special handling because the hazard is recomputed
    // every cycle against the scoreboard that was held during the freeze.
    always_comb begin
        state_next = RUN;
        if (bus.mem_stall_i) begin
            state_next = MEM_FREEZE;
        end else if (bus.flush_i) begin
            state_next = RUN;
        end else if (hazard) begin
            state_next = LOAD_STALL;
        end
    end

    // ---------------- FSM: outputs (same-cycle priority mux) ----------------
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst_i) begin
            ctrl = CTRL_RUN;
        end else if (bus.mem_stall_i) begin
            ctrl = CTRL_FREEZE;
        end else if (bus.flush_i) begin
            ctrl = CTRL_RUN;
        end else if (hazard) begin
            ctrl = CTRL_BUBBLE;
        end
    end

    // ---------------- stall-cycle counter ----------------
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (bus.cnt_clr_i) begin
            stall_cnt_next = '0;
        end else if (ctrl.stall && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.PCWrite_o   = ctrl.pc_write;
    assign bus.Stall_o     = ctrl.stall;
    assign bus.NoOp_o      = ctrl.noop;
    assign bus.Freeze_o    = ctrl.freeze;
    assign bus.state_o     = state_reg;
    assign bus.stall_cnt_o = stall_cnt_reg;

endmodule
